// File: rtl/pe_edge_addr_sequencer_if.sv
// Edge-dataflow sequencer bus: pass handshake, per-pass configuration,
// per-stream advance strobes and the resulting PE addresses / block status.
interface pe_edge_addr_sequencer_if #(
  parameter int KW = 2,
  parameter int OW = 2,
  parameter int IW = 3,
  parameter int BW = 3
);
  logic          start;
  logic [KW:0]   cfg_k_size;
  logic [OW:0]   cfg_o_size;
  logic [BW:0]   cfg_blocks;
  logic          en_k;
  logic          en_i;
  logic          en_o_in;
  logic          en_o_out;

  logic [KW-1:0] k_addr;
  logic [IW-1:0] i_addr;
  logic [OW-1:0] o_in_addr;
  logic [OW-1:0] o_out_addr;
  logic [BW-1:0] i_blk;
  logic [BW-1:0] o_in_blk;
  logic [BW-1:0] o_out_blk;
  logic          o_in_first_blk;
  logic          o_in_last_blk;
  logic          o_out_last_blk;
  logic          busy;
  logic          done;
  logic          cfg_err;

  modport master (
    output start, cfg_k_size, cfg_o_size, cfg_blocks,
    output en_k, en_i, en_o_in, en_o_out,
    input  k_addr, i_addr, o_in_addr, o_out_addr,
    input  i_blk, o_in_blk, o_out_blk,
    input  o_in_first_blk, o_in_last_blk, o_out_last_blk,
    input  busy, done, cfg_err
  );

  modport slave (
    input  start, cfg_k_size, cfg_o_size, cfg_blocks,
    input  en_k, en_i, en_o_in, en_o_out,
    output k_addr, i_addr, o_in_addr, o_out_addr,
    output i_blk, o_in_blk, o_out_blk,
    output o_in_first_blk, o_in_last_blk, o_out_last_blk,
    output busy, done, cfg_err
  );
endinterface

// File: rtl/pe_edge_addr_sequencer.sv
// Wrapping PE address / block sequencer for the K, I, O_In and O_Out edge
// streams, framing one convolution pass with start/busy/done.
module pe_edge_addr_sequencer #(
  parameter int K_MAX   = 4,
  parameter int O_MAX   = 4,
  parameter int KW      = 2,
  parameter int OW      = 2,
  parameter int IW      = 3,
  parameter int BW      = 3,
  parameter int BLK_MAX = 4
) (
  input  logic clk,
  input  logic aclr,
  input  logic sclr,
  pe_edge_addr_sequencer_if.slave seq
);

  localparam logic [KW:0] KLIM = (KW+1)'(K_MAX);
  localparam logic [OW:0] OLIM = (OW+1)'(O_MAX);
  localparam logic [BW:0] BLIM = (BW+1)'(BLK_MAX);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t        state;
  logic [KW-1:0] k_addr;
  logic [IW-1:0] i_addr;
  logic [OW-1:0] o_in_addr;
  logic [OW-1:0] o_out_addr;
  logic [BW-1:0] i_blk;
  logic [BW-1:0] o_in_blk;
  logic [BW-1:0] o_out_blk;
  logic          done;
  logic          cfg_err;

  logic [KW:0]   k_sz;
  logic [OW:0]   o_sz;
  logic [IW:0]   i_sz;
  logic [BW:0]   b_sz;

  logic          cfg_good;
  logic          accept;
  logic          k_wrap;
  logic          i_wrap;
  logic          o_in_wrap;
  logic          o_out_wrap;
  logic          i_blk_last;
  logic          o_in_blk_last;
  logic          o_out_blk_last;
  logic          pass_end;

  function automatic logic cfg_ok(input logic [KW:0] k, input logic [OW:0] o,
                                  input logic [BW:0] b);
    return (k != '0) && (k <= KLIM) && (o != '0) && (o <= OLIM) &&
           (b != '0) && (b <= BLIM);
  endfunction

  assign cfg_good = cfg_ok(seq.cfg_k_size, seq.cfg_o_size, seq.cfg_blocks);
  assign accept   = (state == IDLE) && seq.start && cfg_good && !sclr && !aclr;

  // Wrap points are compared one bit wider so size == 2^W still fits.
  assign k_wrap         = ({1'b0, k_addr}     == k_sz - 1'b1);
  assign i_wrap         = ({1'b0, i_addr}     == i_sz - 1'b1);
  assign o_in_wrap      = ({1'b0, o_in_addr}  == o_sz - 1'b1);
  assign o_out_wrap     = ({1'b0, o_out_addr} == o_sz - 1'b1);
  assign i_blk_last     = ({1'b0, i_blk}      == b_sz - 1'b1);
  assign o_in_blk_last  = ({1'b0, o_in_blk}   == b_sz - 1'b1);
  assign o_out_blk_last = ({1'b0, o_out_blk}  == b_sz - 1'b1);
  assign pass_end       = seq.en_o_out && o_out_wrap && o_out_blk_last;

  // Configuration is latched only on an accepted start and frozen for the pass.
  always_ff @(posedge clk) begin
    if (accept) begin
      k_sz <= seq.cfg_k_size;
      o_sz <= seq.cfg_o_size;
      i_sz <= (IW+1)'(seq.cfg_k_size) + (IW+1)'(seq.cfg_o_size) - (IW+1)'(1);
      b_sz <= seq.cfg_blocks;
    end
  end

  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      state      <= IDLE;
      k_addr     <= '0;
      i_addr     <= '0;
      o_in_addr  <= '0;
      o_out_addr <= '0;
      i_blk      <= '0;
      o_in_blk   <= '0;
      o_out_blk  <= '0;
      done       <= 1'b0;
      cfg_err    <= 1'b0;
    end else if (sclr) begin
      state      <= IDLE;
      k_addr     <= '0;
      i_addr     <= '0;
      o_in_addr  <= '0;
      o_out_addr <= '0;
      i_blk      <= '0;
      o_in_blk   <= '0;
      o_out_blk  <= '0;
      done       <= 1'b0;
      cfg_err    <= 1'b0;
    end else begin
      done    <= 1'b0;
      cfg_err <= 1'b0;
      case (state)
        IDLE: begin
          // Counters are already zero in IDLE, so acceptance only changes state.
          if (seq.start) begin
            if (cfg_good) state   <= RUN;
            else          cfg_err <= 1'b1;
          end
        end
        RUN: begin
          if (pass_end) begin
            state      <= IDLE;
            done       <= 1'b1;
            k_addr     <= '0;
            i_addr     <= '0;
            o_in_addr  <= '0;
            o_out_addr <= '0;
            i_blk      <= '0;
            o_in_blk   <= '0;
            o_out_blk  <= '0;
          end else begin
            if (seq.en_k)
              k_addr <= k_wrap ? '0 : k_addr + 1'b1;
            if (seq.en_i) begin
              i_addr <= i_wrap ? '0 : i_addr + 1'b1;
              if (i_wrap) i_blk <= i_blk_last ? '0 : i_blk + 1'b1;
            end
            if (seq.en_o_in) begin
              o_in_addr <= o_in_wrap ? '0 : o_in_addr + 1'b1;
              if (o_in_wrap) o_in_blk <= o_in_blk_last ? '0 : o_in_blk + 1'b1;
            end
            if (seq.en_o_out) begin
              o_out_addr <= o_out_wrap ? '0 : o_out_addr + 1'b1;
              if (o_out_wrap) o_out_blk <= o_out_blk_last ? '0 : o_out_blk + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign seq.k_addr         = k_addr;
  assign seq.i_addr         = i_addr;
  assign seq.o_in_addr      = o_in_addr;
  assign seq.o_out_addr     = o_out_addr;
  assign seq.i_blk          = i_blk;
  assign seq.o_in_blk       = o_in_blk;
  assign seq.o_out_blk      = o_out_blk;
  assign seq.busy           = (state == RUN);
  assign seq.done           = done;
  assign seq.cfg_err        = cfg_err;
  // Block flags follow the counters; last-block flags are gated off in IDLE.
  assign seq.o_in_first_blk = (o_in_blk == '0);
  assign seq.o_in_last_blk  = (state == RUN) && o_in_blk_last;
  assign seq.o_out_last_blk = (state == RUN) && o_out_blk_last;

endmodule

// File: tb/tb_pe_edge_addr_sequencer.sv
// Bench for pe_edge_addr_sequencer: vector table, directed corner sequences
// and random traffic against a count-based reference model.
module tb_pe_edge_addr_sequencer;
  localparam int K_MAX = 4, O_MAX = 4, KW = 2, OW = 2, IW = 3, BW = 3, BLK_MAX = 4;

  logic clk = 1'b0;
  logic aclr = 1'b0;
  logic sclr = 1'b0;
  int total = 0;
  int bad = 0;

  pe_edge_addr_sequencer_if #(.KW(KW), .OW(OW), .IW(IW), .BW(BW)) sif ();

  pe_edge_addr_sequencer #(.K_MAX(K_MAX), .O_MAX(O_MAX), .KW(KW), .OW(OW), .IW(IW),
                           .BW(BW), .BLK_MAX(BLK_MAX))
    dut (.clk(clk), .aclr(aclr), .sclr(sclr), .seq(sif));

  always #5 clk = ~clk;

  // Reference model: a pass is described by how many times each stream advanced.
  bit m_busy, m_done, m_err;
  int mK, mO, mI, mB, nk, ni, noi, noo;

  function automatic logic [23:0] pack(input bit busy, input bit dn, input bit err,
      input bit first, input bit il, input bit ol, input int k, input int i,
      input int oi, input int oo, input int ib, input int oib, input int oob);
    return {busy, dn, err, first, il, ol, k[1:0], i[2:0], oi[1:0], oo[1:0],
            ib[2:0], oib[2:0], oob[2:0]};
  endfunction

  function automatic logic [23:0] dut_vec();
    return pack(sif.busy, sif.done, sif.cfg_err, sif.o_in_first_blk, sif.o_in_last_blk,
                sif.o_out_last_blk, int'(sif.k_addr), int'(sif.i_addr), int'(sif.o_in_addr),
                int'(sif.o_out_addr), int'(sif.i_blk), int'(sif.o_in_blk), int'(sif.o_out_blk));
  endfunction

  function automatic logic [23:0] model_vec();
    int k = 0, i = 0, oi = 0, oo = 0, ib = 0, oib = 0, oob = 0;
    if (m_busy) begin
      k = nk % mK;   i = ni % mI;   ib = (ni / mI) % mB;
      oi = noi % mO; oib = (noi / mO) % mB;
      oo = noo % mO; oob = (noo / mO) % mB;
    end
    return pack(m_busy, m_done, m_err, oib == 0, m_busy && oib == mB - 1,
                m_busy && oob == mB - 1, k, i, oi, oo, ib, oib, oob);
  endfunction

  task automatic model_step(input bit s_clr, input bit st, input int ks, input int os,
                            input int bs, input logic [3:0] en);
    m_done = 0;
    m_err  = 0;
    if (s_clr) begin
      m_busy = 0; nk = 0; ni = 0; noi = 0; noo = 0;
    end else if (!m_busy) begin
      if (st) begin
        if (ks < 1 || ks > K_MAX || os < 1 || os > O_MAX || bs < 1 || bs > BLK_MAX)
          m_err = 1;
        else begin
          m_busy = 1; mK = ks; mO = os; mI = ks + os - 1; mB = bs;
          nk = 0; ni = 0; noi = 0; noo = 0;
        end
      end
    end else if (en[0] && noo + 1 == mO * mB) begin
      m_done = 1; m_busy = 0; nk = 0; ni = 0; noi = 0; noo = 0;
    end else begin
      nk += int'(en[3]); ni += int'(en[2]); noi += int'(en[1]); noo += int'(en[0]);
    end
  endtask

  // en bits: {k, i, o_in, o_out}
  task automatic drive(input bit s_clr, input bit st, input int ks, input int os,
                       input int bs, input logic [3:0] en);
    sclr = s_clr;
    sif.start = st;
    sif.cfg_k_size = ks[KW:0];
    sif.cfg_o_size = os[OW:0];
    sif.cfg_blocks = bs[BW:0];
    sif.en_k = en[3]; sif.en_i = en[2]; sif.en_o_in = en[1]; sif.en_o_out = en[0];
    model_step(s_clr, st, ks, os, bs, en);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cmp_vec(input string name, input logic [23:0] exp);
    logic [23:0] act;
    act = dut_vec();
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cmp_model(input string name);
    cmp_vec(name, model_vec());
  endtask

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    bit          s_clr;
    bit          st;
    int          ks, os, bs;
    logic [3:0]  en;
    logic [23:0] exp;
  } vec_t;
  vec_t tbl[$];

  task automatic add_row(input bit st, input int ks, input int os, input int bs,
                         input logic [3:0] en, input logic [23:0] exp);
    vec_t v;
    v.s_clr = 0; v.st = st; v.ks = ks; v.os = os; v.bs = bs; v.en = en; v.exp = exp;
    tbl.push_back(v);
  endtask

  initial begin
    aclr = 1'b1;
    drive(1, 0, 0, 0, 0, 4'b0000);
    #3;
    cmp_model("reset_state");
    cmp_vec("reset_const", pack(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    #4 aclr = 1'b0;
    drive(0, 0, 0, 0, 0, 4'b0000);
    tick();

    // Rejected starts, then K=2 O=3 B=2 (I=4) pass with cfg/start noise during RUN.
    add_row(1, 4, 4, 0, 4'b0000, pack(0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    add_row(1, 5, 4, 4, 4'b0000, pack(0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    add_row(1, 4, 5, 4, 4'b1111, pack(0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    add_row(1, 2, 3, 2, 4'b0000, pack(1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    add_row(1, 0, 0, 0, 4'b1000, pack(1, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0));
    add_row(0, 4, 4, 4, 4'b1000, pack(1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    add_row(0, 1, 1, 1, 4'b1000, pack(1, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0));
    add_row(0, 2, 3, 2, 4'b0010, pack(1, 0, 0, 1, 0, 0, 1, 0, 1, 0, 0, 0, 0));
    add_row(0, 2, 3, 2, 4'b0010, pack(1, 0, 0, 1, 0, 0, 1, 0, 2, 0, 0, 0, 0));
    add_row(0, 2, 3, 2, 4'b0010, pack(1, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 1, 0));
    add_row(0, 2, 3, 2, 4'b0100, pack(1, 0, 0, 0, 1, 0, 1, 1, 0, 0, 0, 1, 0));
    add_row(0, 2, 3, 2, 4'b0100, pack(1, 0, 0, 0, 1, 0, 1, 2, 0, 0, 0, 1, 0));
    add_row(0, 2, 3, 2, 4'b0100, pack(1, 0, 0, 0, 1, 0, 1, 3, 0, 0, 0, 1, 0));
    add_row(0, 2, 3, 2, 4'b0100, pack(1, 0, 0, 0, 1, 0, 1, 0, 0, 0, 1, 1, 0));
    add_row(0, 2, 3, 2, 4'b0001, pack(1, 0, 0, 0, 1, 0, 1, 0, 0, 1, 1, 1, 0));
    add_row(0, 2, 3, 2, 4'b0001, pack(1, 0, 0, 0, 1, 0, 1, 0, 0, 2, 1, 1, 0));
    add_row(0, 2, 3, 2, 4'b0001, pack(1, 0, 0, 0, 1, 1, 1, 0, 0, 0, 1, 1, 1));
    add_row(0, 2, 3, 2, 4'b0001, pack(1, 0, 0, 0, 1, 1, 1, 0, 0, 1, 1, 1, 1));
    add_row(0, 2, 3, 2, 4'b0001, pack(1, 0, 0, 0, 1, 1, 1, 0, 0, 2, 1, 1, 1));
    add_row(0, 2, 3, 2, 4'b0001, pack(0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    add_row(0, 2, 3, 2, 4'b1111, pack(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    for (int r = 0; r < tbl.size(); r++) begin
      drive(tbl[r].s_clr, tbl[r].st, tbl[r].ks, tbl[r].os, tbl[r].bs, tbl[r].en);
      tick();
      cmp_vec($sformatf("table_row%0d", r), tbl[r].exp);
    end

    // Default pass K=4 O=4 B=4.
    drive(0, 1, 4, 4, 4, 4'b0000); tick(); cmp_model("dp_start");
    for (int j = 0; j < 7; j++) begin
      drive(0, 0, 4, 4, 4, 4'b0100); tick(); cmp_model("dp_en_i");
      chk("dp_i_addr", int'(sif.i_addr), (j + 1) % 7);
    end
    chk("dp_i_blk", int'(sif.i_blk), 1);
    for (int j = 0; j < 16; j++) begin
      drive(0, 0, 4, 4, 4, 4'b0001); tick(); cmp_model("dp_en_o_out");
      chk("dp_done", int'(sif.done), (j == 15) ? 1 : 0);
    end
    chk("dp_busy_after", int'(sif.busy), 0);
    drive(0, 0, 4, 4, 4, 4'b0000); tick(); chk("dp_done_single", int'(sif.done), 0);

    // Abort via sclr with o_in_blk == 2, then a fresh start.
    drive(0, 1, 4, 2, 4, 4'b0000); tick();
    for (int j = 0; j < 4; j++) begin
      drive(0, 0, 4, 2, 4, 4'b0010); tick(); cmp_model("ab_en_o_in");
    end
    chk("ab_o_in_blk", int'(sif.o_in_blk), 2);
    drive(1, 1, 4, 2, 4, 4'b1111); tick(); cmp_model("ab_sclr");
    chk("ab_busy", int'(sif.busy), 0);
    chk("ab_no_done", int'(sif.done), 0);
    chk("ab_blk_clr", int'(sif.o_in_blk), 0);
    drive(0, 1, 3, 3, 3, 4'b0000); tick(); chk("ab_restart", int'(sif.busy), 1);
    drive(0, 0, 3, 3, 3, 4'b1111); tick(); cmp_model("ab_after_restart");

    // Asynchronous clear in the middle of a cycle.
    #2 aclr = 1'b1;
    model_step(1, 0, 0, 0, 0, 4'b0000);
    #1 cmp_model("aclr_mid");
    chk("aclr_first", int'(sif.o_in_first_blk), 1);
    #1 aclr = 1'b0;
    drive(0, 0, 0, 0, 0, 4'b0000); tick();

    // start held through done: one-cycle IDLE gap before the next pass.
    drive(0, 1, 1, 1, 1, 4'b0000); tick(); chk("bb_busy1", int'(sif.busy), 1);
    drive(0, 1, 1, 1, 1, 4'b0001); tick(); chk("bb_done", int'(sif.done), 1);
    chk("bb_gap", int'(sif.busy), 0);
    drive(0, 1, 1, 1, 1, 4'b0000); tick(); chk("bb_busy2", int'(sif.busy), 1);
    cmp_model("bb_state");
    drive(1, 0, 0, 0, 0, 4'b0000); tick();

    // All enables every cycle with cfg inputs scrambled: done after O*B = 6.
    drive(0, 1, 3, 2, 3, 4'b0000); tick();
    for (int j = 0; j < 6; j++) begin
      drive(0, $urandom_range(0, 1), $urandom_range(0, 7), $urandom_range(0, 7),
            $urandom_range(0, 15), 4'b1111);
      tick(); cmp_model("cc_step");
      chk("cc_done", int'(sif.done), (j == 5) ? 1 : 0);
    end

    // Random traffic against the model.
    drive(1, 0, 0, 0, 0, 4'b0000); tick();
    for (int c = 0; c < 3000; c++) begin
      drive(($urandom % 64) == 0, ($urandom % 4) == 0, $urandom_range(0, 5),
            $urandom_range(0, 5), $urandom_range(0, 5), 4'($urandom));
      tick();
      cmp_model("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
